div_error_monitor: RTL

Sequential error-characterisation stage placed directly downstream of the 16-by-8 approximate array dividers. It captures one operand pair together with the approximate quotient and remainder the divider produced for it. It then recomputes the exact result with an 8-step restoring divider and accumulates mean-absolute-error statistics on the quotient. Sweeps of approximate subtractor cells are scored with it in simulation and on FPGA.

---
 rtl/div_mon_pkg.sv | 35 +++
 rtl/restoring_div_step.sv | 38 +++
 rtl/div_error_monitor.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_mon_pkg.sv
// div_mon_pkg
// Shared definitions for the divider error monitor: operand widths, the
// monitor state encoding and a saturating adder used by every statistic.
// No ports (package).

package div_mon_pkg;

   localparam int N_W = 16;
   localparam int D_W = 8;
   localparam int Q_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Adds amount to value and clamps the result at limit. The callers keep
   // value <= limit, so the clamp is the only way the sum can leave range.
   // Operands are carried in 32 bits; callers cast back to their own width.
   function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                           input logic [31:0] amount,
                                           input logic [31:0] limit);
      logic [32:0] sum;
      logic [31:0] result;
      sum = {1'b0, value} + {1'b0, amount};
      if (sum > {1'b0, limit}) begin
         result = limit;
      end else begin
         result = sum[31:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/restoring_div_step.sv
// restoring_div_step
// One combinational step of a restoring divider: shifts the next dividend
// bit into the partial remainder and subtracts the divisor if it fits.
// Ports:
//   p_in   - current 9-bit partial remainder
//   n_bit  - dividend bit brought down in this step
//   d      - divisor
//   p_out  - partial remainder after the step
//   q_bit  - quotient bit produced by the step

module restoring_div_step
   import div_mon_pkg::*;
(
   input  logic [8:0]     p_in,
   input  logic           n_bit,
   input  logic [D_W-1:0] d,
   output logic [8:0]     p_out,
   output logic           q_bit
);

   logic [9:0] t;
   logic [8:0] diff;

   // p_in never reaches d, so t fits in 9 bits in practice; keeping the top
   // bit in the compare makes the step correct for any p_in anyway.
   always_comb begin
      t    = {p_in, n_bit};
      diff = t[8:0] - {1'b0, d};
      if (t >= {2'b00, d}) begin
         q_bit = 1'b1;
         p_out = diff;
      end else begin
         q_bit = 1'b0;
         p_out = t[8:0];
      end
   end

endmodule

// File: rtl/div_error_monitor.sv
// div_error_monitor
// Captures one operand pair with the approximate quotient/remainder produced
// by an approximate divider, recomputes the exact result with an 8-step
// restoring divider and accumulates quotient error statistics.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid / in_ready   - sample handshake (in_ready high only when idle)
//   n, d, q_apx, r_apx    - dividend, divisor and approximate results
//   clr                   - synchronous clear of all statistics
//   res_valid, res_ovf    - per-sample result pulse and overflow flag
//   q_exact, r_exact      - exact quotient and remainder of the last sample
//   q_err                 - |q_apx - q_exact| of the last sample
//   err_sum, sample_cnt   - saturating error sum and counted-sample count
//   max_err               - largest quotient error seen
//   mism_cnt, ovf_cnt     - saturating mismatch and overflow counts

module div_error_monitor
   import div_mon_pkg::*;
#(
   parameter int SUM_W = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_W-1:0]   n,
   input  logic [D_W-1:0]   d,
   input  logic [Q_W-1:0]   q_apx,
   input  logic [Q_W-1:0]   r_apx,
   input  logic             clr,
   output logic             res_valid,
   output logic             res_ovf,
   output logic [Q_W-1:0]   q_exact,
   output logic [Q_W-1:0]   r_exact,
   output logic [Q_W-1:0]   q_err,
   output logic [SUM_W-1:0] err_sum,
   output logic [SUM_W-1:0] sample_cnt,
   output logic [Q_W-1:0]   max_err,
   output logic [CNT_W-1:0] mism_cnt,
   output logic [CNT_W-1:0] ovf_cnt
);

   // Saturation limits expressed in the 32-bit width of sat_inc; SUM_W and
   // CNT_W are therefore limited to 32.
   localparam logic [31:0] SUM_MAX = 32'((64'd1 << SUM_W) - 64'd1);
   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   state_t           state_q,      state_d;
   logic [2:0]       step_q,       step_d;
   logic [D_W-1:0]   n_lo_q,       n_lo_d;
   logic [D_W-1:0]   d_q,          d_d;
   logic [Q_W-1:0]   q_apx_q,      q_apx_d;
   logic [Q_W-1:0]   r_apx_q,      r_apx_d;
   logic [8:0]       p_q,          p_d;
   logic [Q_W-1:0]   q_acc_q,      q_acc_d;
   logic             res_valid_q,  res_valid_d;
   logic             res_ovf_q,    res_ovf_d;
   logic [Q_W-1:0]   q_exact_q,    q_exact_d;
   logic [Q_W-1:0]   r_exact_q,    r_exact_d;
   logic [Q_W-1:0]   q_err_q,      q_err_d;
   logic [SUM_W-1:0] err_sum_q,    err_sum_d;
   logic [SUM_W-1:0] sample_cnt_q, sample_cnt_d;
   logic [Q_W-1:0]   max_err_q,    max_err_d;
   logic [CNT_W-1:0] mism_cnt_q,   mism_cnt_d;
   logic [CNT_W-1:0] ovf_cnt_q,    ovf_cnt_d;

   logic [8:0]       p_next;
   logic             q_bit;
   logic             in_ovf;
   logic             sample_mism;

   // Only the low dividend byte is kept after acceptance: the high byte is
   // loaded straight into the partial remainder, which is where it lives
   // for the rest of the computation.
   restoring_div_step u_step (
      .p_in  (p_q),
      .n_bit (n_lo_q[3'd7 - step_q]),
      .d     (d_q),
      .p_out (p_next),
      .q_bit (q_bit)
   );

   // A quotient that does not fit in 8 bits (or a zero divisor) cannot be
   // produced by the divider, so such samples are only counted as overflow.
   assign in_ovf      = (d == '0) || (n[N_W-1:D_W] >= d);
   assign sample_mism = (q_apx_q != q_exact_q) || (r_apx_q != r_exact_q);

   always_comb begin
      state_d      = state_q;
      step_d       = step_q;
      n_lo_d       = n_lo_q;
      d_d          = d_q;
      q_apx_d      = q_apx_q;
      r_apx_d      = r_apx_q;
      p_d          = p_q;
      q_acc_d      = q_acc_q;
      res_valid_d  = 1'b0;
      res_ovf_d    = res_ovf_q;
      q_exact_d    = q_exact_q;
      r_exact_d    = r_exact_q;
      q_err_d      = q_err_q;
      err_sum_d    = err_sum_q;
      sample_cnt_d = sample_cnt_q;
      max_err_d    = max_err_q;
      mism_cnt_d   = mism_cnt_q;
      ovf_cnt_d    = ovf_cnt_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               n_lo_d  = n[D_W-1:0];
               d_d     = d;
               q_apx_d = q_apx;
               r_apx_d = r_apx;
               step_d  = 3'd0;
               q_acc_d = '0;
               p_d     = {1'b0, n[N_W-1:D_W]};
               if (in_ovf) begin
                  state_d     = DONE;
                  res_valid_d = 1'b1;
                  res_ovf_d   = 1'b1;
                  q_exact_d   = '0;
                  r_exact_d   = '0;
                  q_err_d     = '0;
               end else begin
                  state_d = CALC;
               end
            end
         end

         // Step k fills quotient bit 7-k, so the quotient is complete once
         // the step-7 bit has been written into q_acc_d.
         CALC: begin
            p_d                     = p_next;
            q_acc_d[3'd7 - step_q]  = q_bit;
            step_d                  = step_q + 3'd1;
            if (step_q == 3'd7) begin
               state_d     = DONE;
               step_d      = 3'd0;
               res_valid_d = 1'b1;
               res_ovf_d   = 1'b0;
               q_exact_d   = q_acc_d;
               r_exact_d   = p_next[7:0];
               if (q_apx_q >= q_acc_d) begin
                  q_err_d = q_apx_q - q_acc_d;
               end else begin
                  q_err_d = q_acc_d - q_apx_q;
               end
            end
         end

         // Statistics are taken from the registered result of this sample.
         DONE: begin
            state_d = IDLE;
            if (res_ovf_q) begin
               ovf_cnt_d = CNT_W'(sat_inc(32'(ovf_cnt_q), 32'd1, CNT_MAX));
            end else begin
               err_sum_d    = SUM_W'(sat_inc(32'(err_sum_q), 32'(q_err_q), SUM_MAX));
               sample_cnt_d = SUM_W'(sat_inc(32'(sample_cnt_q), 32'd1, SUM_MAX));
               if (q_err_q > max_err_q) begin
                  max_err_d = q_err_q;
               end
               if (sample_mism) begin
                  mism_cnt_d = CNT_W'(sat_inc(32'(mism_cnt_q), 32'd1, CNT_MAX));
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // A clear overrides any update on the same edge, including the one
      // from DONE, but leaves the computation and result registers alone.
      if (clr) begin
         err_sum_d    = '0;
         sample_cnt_d = '0;
         max_err_d    = '0;
         mism_cnt_d   = '0;
         ovf_cnt_d    = '0;
      end
   end

   // All state, operand, result and statistic registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         step_q       <= '0;
         n_lo_q       <= '0;
         d_q          <= '0;
         q_apx_q      <= '0;
         r_apx_q      <= '0;
         p_q          <= '0;
         q_acc_q      <= '0;
         res_valid_q  <= 1'b0;
         res_ovf_q    <= 1'b0;
         q_exact_q    <= '0;
         r_exact_q    <= '0;
         q_err_q      <= '0;
         err_sum_q    <= '0;
         sample_cnt_q <= '0;
         max_err_q    <= '0;
         mism_cnt_q   <= '0;
         ovf_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         n_lo_q       <= n_lo_d;
         d_q          <= d_d;
         q_apx_q      <= q_apx_d;
         r_apx_q      <= r_apx_d;
         p_q          <= p_d;
         q_acc_q      <= q_acc_d;
         res_valid_q  <= res_valid_d;
         res_ovf_q    <= res_ovf_d;
         q_exact_q    <= q_exact_d;
         r_exact_q    <= r_exact_d;
         q_err_q      <= q_err_d;
         err_sum_q    <= err_sum_d;
         sample_cnt_q <= sample_cnt_d;
         max_err_q    <= max_err_d;
         mism_cnt_q   <= mism_cnt_d;
         ovf_cnt_q    <= ovf_cnt_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign res_valid  = res_valid_q;
   assign res_ovf    = res_ovf_q;
   assign q_exact    = q_exact_q;
   assign r_exact    = r_exact_q;
   assign q_err      = q_err_q;
   assign err_sum    = err_sum_q;
   assign sample_cnt = sample_cnt_q;
   assign max_err    = max_err_q;
   assign mism_cnt   = mism_cnt_q;
   assign ovf_cnt    = ovf_cnt_q;

endmodule
